// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM encoding and default
// reset / exception addresses.
package pc_sequencer_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_e;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry and
// the count saturates at DEPTH.
module ras_stack
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_replace,
  input  logic [W-1:0]                 i_data,
  output logic [W-1:0]                 o_top,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next free slot; the top of stack sits just below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign o_top   = mem_q[top_idx];
  assign o_count = cnt_q;
  assign o_empty = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (i_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_clear) begin
      if (i_push)         mem_q[ptr_q]   <= i_data;
      else if (i_replace) mem_q[top_idx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential stepping plus exception, halt, stall and
// jump/call/return redirects, with a small return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        INST_BYTES = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = ADDR_W'(DEFAULT_RESET_ADDR),
  parameter logic [ADDR_W-1:0]  EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR),
  parameter int unsigned        RAS_DEPTH  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_jump,
  input  logic [ADDR_W-1:0]              i_jump_addr,
  input  logic                           i_call,
  input  logic                           i_ret,
  input  logic                           i_exc,
  input  logic                           i_stall,
  input  logic                           i_halt,
  input  logic                           i_resume,
  output logic [ADDR_W-1:0]              o_pc,
  output logic [ADDR_W-1:0]              o_pc4,
  output logic [ADDR_W-1:0]              o_epc,
  output logic                           o_halted,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_ras_count,
  output logic                           o_ras_underflow
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc4_q, epc_q, epc_d;
  logic              uf_q, uf_d;

  logic              ras_clear, ras_push, ras_pop, ras_replace, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (ras_clear),
    .i_push    (ras_push),
    .i_pop     (ras_pop),
    .i_replace (ras_replace),
    .i_data    (pc4_q),
    .o_top     (ras_top),
    .o_count   (o_ras_count),
    .o_empty   (ras_empty)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    uf_d        = 1'b0;
    ras_clear   = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    if (i_exc) begin
      pc_d      = EXC_VECTOR;
      epc_d     = pc_q;
      ras_clear = 1'b1;
      state_d   = ST_RUN;
    end else if (state_q == ST_HALTED || i_halt) begin
      // Resume only counts when halt is not re-asserted in the same cycle.
      if (state_q == ST_RUN)  state_d = ST_HALTED;
      else if (i_resume && !i_halt) state_d = ST_RUN;
    end else if (i_stall) begin
      pc_d = pc_q;
    end else if (i_jump) begin
      pc_d = (i_ret && !ras_empty) ? ras_top : i_jump_addr;
      if (i_call && i_ret) begin
        ras_replace = !ras_empty;
        ras_push    = ras_empty;
        uf_d        = ras_empty;
      end else if (i_call) begin
        ras_push = 1'b1;
      end else if (i_ret) begin
        ras_pop = 1'b1;
        uf_d    = ras_empty;
      end
    end else begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_ADDR;
      pc4_q   <= RESET_ADDR + STEP;
      epc_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc_d + STEP;
      epc_q   <= epc_d;
      uf_q    <= uf_d;
    end
  end

  assign o_pc            = pc_q;
  assign o_pc4           = pc4_q;
  assign o_epc           = epc_q;
  assign o_halted        = (state_q == ST_HALTED);
  assign o_ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, compared against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst, jump, call, ret, exc, stall, halt, resume;
  logic [31:0] jaddr;
  logic [31:0] o_pc, o_pc4, o_epc;
  logic        o_halted, o_ras_underflow;
  logic [2:0]  o_ras_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: the RAS is a plain queue, newest entry at the back.
  logic [31:0] mPc, mEpc;
  bit          mHalted, mUf;
  logic [31:0] mRas[$];

  pc_sequencer dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_jump          (jump),
    .i_jump_addr     (jaddr),
    .i_call          (call),
    .i_ret           (ret),
    .i_exc           (exc),
    .i_stall         (stall),
    .i_halt          (halt),
    .i_resume        (resume),
    .o_pc            (o_pc),
    .o_pc4           (o_pc4),
    .o_epc           (o_epc),
    .o_halted        (o_halted),
    .o_ras_count     (o_ras_count),
    .o_ras_underflow (o_ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("pc", o_pc, mPc);
    checkVal("pc4", o_pc4, mPc + 32'd4);
    checkVal("epc", o_epc, mEpc);
    checkVal("halted", {31'b0, o_halted}, {31'b0, mHalted});
    checkVal("ras_count", {29'b0, o_ras_count}, 32'(mRas.size()));
    checkVal("underflow", {31'b0, o_ras_underflow}, {31'b0, mUf});
  endtask

  task automatic modelStep();
    logic [31:0] tgt;
    mUf = 1'b0;
    if (rst) begin
      mPc = 32'h0; mEpc = 32'h0; mHalted = 1'b0; mRas.delete();
    end else if (exc) begin
      mEpc = mPc; mPc = 32'h80; mHalted = 1'b0; mRas.delete();
    end else if (mHalted || halt) begin
      if (!mHalted) mHalted = 1'b1;
      else if (resume && !halt) mHalted = 1'b0;
    end else if (stall) begin
      mPc = mPc;
    end else if (jump) begin
      tgt = (ret && mRas.size() > 0) ? mRas[mRas.size()-1] : jaddr;
      if (call && ret) begin
        if (mRas.size() > 0) mRas[mRas.size()-1] = mPc + 32'd4;
        else begin mRas.push_back(mPc + 32'd4); mUf = 1'b1; end
      end else if (call) begin
        mRas.push_back(mPc + 32'd4);
        if (mRas.size() > 4) void'(mRas.pop_front());
      end else if (ret) begin
        if (mRas.size() > 0) void'(mRas.pop_back());
        else mUf = 1'b1;
      end
      mPc = tgt;
    end else begin
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic applyStimulus(input bit iRst, input bit iExc, input bit iStall, input bit iHalt,
                               input bit iResume, input bit iJump, input bit iCall, input bit iRet,
                               input logic [31:0] iAddr);
    rst = iRst; exc = iExc; stall = iStall; halt = iHalt; resume = iResume;
    jump = iJump; call = iCall; ret = iRet; jaddr = iAddr;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] retAddrs [4];
    retAddrs[0] = 32'h504; retAddrs[1] = 32'h404; retAddrs[2] = 32'h304; retAddrs[3] = 32'h204;
    rst = 1; exc = 0; stall = 0; halt = 0; resume = 0; jump = 0; call = 0; ret = 0; jaddr = 0;
    $display("[TB] reset and free-running");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    checkVal("reset_pc", o_pc, 32'h0);
    checkVal("reset_pc4", o_pc4, 32'h4);
    for (int i = 0; i < 4; i++) idle();
    checkVal("free_pc", o_pc, 32'h10);

    $display("[TB] call / ret");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 32'h100);
    checkVal("call_pc", o_pc, 32'h100);
    checkVal("call_cnt", {29'b0, o_ras_count}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h999);
    checkVal("ret_pc", o_pc, 32'h14);

    $display("[TB] RAS overflow and underflow");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 32'((i + 2) << 8));
    checkVal("full_cnt", {29'b0, o_ras_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'hDEAD_0000);
      checkVal("ret_order", o_pc, retAddrs[i]);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'hDEAD_0000);
    checkVal("uf_pc", o_pc, 32'hDEAD_0000);
    checkVal("uf_pulse", {31'b0, o_ras_underflow}, 32'd1);
    idle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 32'h700);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 32'h800);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h900);
    checkVal("callret_pc", o_pc, 32'h704);

    $display("[TB] halt / resume");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h20);
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 32'h300);
    checkVal("halt_pc", o_pc, 32'h20);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 32'h300);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
    idle();
    checkVal("resume_pc", o_pc, 32'h24);

    $display("[TB] exceptions");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 32'h40);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 32'h0);
    checkVal("exc_pc", o_pc, 32'h80);
    checkVal("exc_epc", o_epc, 32'h40);
    idle();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    checkVal("exc_halt_epc", o_epc, 32'h84);

    $display("[TB] wrap and reset priority");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFF8);
    idle();
    idle();
    checkVal("wrap_pc", o_pc, 32'h0);
    checkVal("wrap_pc4", o_pc4, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 32'h1234);
    checkVal("rst_jump_pc", o_pc, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    1'($urandom), 1'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
